// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Time-multiplexed driver for a DIGITS-wide common-anode seven-segment
//   display. A prescaler divides clk into digit slots. A double-buffered
//   frame of hex nibbles and decimal points is scanned one digit per slot.
//   New frames are committed only at a frame wrap, so the display never
//   tears.
//
// Ports
//   i_clk          system clock
//   i_rst          synchronous active-high reset
//   i_data         4*DIGITS hex nibbles, digit 0 in bits [3:0]
//   i_dp_in        decimal point request per digit (active-high)
//   i_digit_en     per-digit enable, read live
//   i_lz_en        leading-zero suppression enable, read live
//   i_load         strobe capturing i_data/i_dp_in into the pending buffer
//   o_seg          active-low segments, bit 0 = a ... bit 6 = g
//   o_dp           active-low decimal point
//   o_an           active-low anode selects
//   o_frame_done   one-cycle pulse after each frame wrap
//   o_busy         pending frame waiting for commit
module seg7_scan_driver #(
  parameter int DIGITS  = 8,
  parameter int CLK_DIV = 100000,
  parameter int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [4*DIGITS-1:0]   i_data,
  input  logic [DIGITS-1:0]     i_dp_in,
  input  logic [DIGITS-1:0]     i_digit_en,
  input  logic                  i_lz_en,
  input  logic                  i_load,
  output logic [6:0]            o_seg,
  output logic                  o_dp,
  output logic [DIGITS-1:0]     o_an,
  output logic                  o_frame_done,
  output logic                  o_busy
);

  localparam int PS_W = $clog2(CLK_DIV);
  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [PS_W-1:0]       r_presc;
  logic [IDX_W-1:0]      r_idx;
  logic [4*DIGITS-1:0]   r_disp_data;
  logic [DIGITS-1:0]     r_disp_dp;
  logic [4*DIGITS-1:0]   r_pend_data;
  logic [DIGITS-1:0]     r_pend_dp;
  logic                  r_pend_valid;

  logic                  w_tick;
  logic                  w_wrap;
  logic [DIGITS-1:0]     w_suppress;
  logic [3:0]            w_nib;
  logic                  w_dp_bit;
  logic                  w_en;
  logic                  w_sup;
  logic [DIGITS-1:0]     w_an_sel;

  function automatic logic [6:0] f_decode(input logic [3:0] nib);
    case (nib)
      4'h0: f_decode = 7'h40;
      4'h1: f_decode = 7'h79;
      4'h2: f_decode = 7'h24;
      4'h3: f_decode = 7'h30;
      4'h4: f_decode = 7'h19;
      4'h5: f_decode = 7'h12;
      4'h6: f_decode = 7'h02;
      4'h7: f_decode = 7'h78;
      4'h8: f_decode = 7'h00;
      4'h9: f_decode = 7'h10;
      4'hA: f_decode = 7'h08;
      4'hB: f_decode = 7'h03;
      4'hC: f_decode = 7'h46;
      4'hD: f_decode = 7'h21;
      4'hE: f_decode = 7'h06;
      default: f_decode = 7'h0E;
    endcase
  endfunction

  assign w_tick = (r_presc == PS_LAST);
  assign w_wrap = w_tick && (r_idx == IDX_LAST);

  // Scan timing: prescaler and digit index.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      if (w_tick)
        r_idx <= w_wrap ? '0 : r_idx + 1'b1;
    end
  end

  // Double buffer. The commit uses the pending contents from before this
  // edge, so a load landing on the wrap edge waits for the following wrap.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_disp_data  <= '0;
      r_disp_dp    <= '0;
      r_pend_data  <= '0;
      r_pend_dp    <= '0;
      r_pend_valid <= 1'b0;
    end else begin
      if (w_wrap && r_pend_valid) begin
        r_disp_data <= r_pend_data;
        r_disp_dp   <= r_pend_dp;
      end
      if (i_load) begin
        r_pend_data  <= i_data;
        r_pend_dp    <= i_dp_in;
        r_pend_valid <= 1'b1;
      end else if (w_wrap) begin
        r_pend_valid <= 1'b0;
      end
    end
  end

  // A digit is a leading zero when it and every digit above it hold 0.
  always_comb begin
    logic w_zero_run;
    w_zero_run = 1'b1;
    w_suppress = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      w_zero_run    = w_zero_run & (r_disp_data[4*i +: 4] == 4'h0);
      w_suppress[i] = w_zero_run & (i != 0);
    end
  end

  // Select the fields of the digit currently being scanned.
  always_comb begin
    w_nib    = 4'h0;
    w_dp_bit = 1'b0;
    w_en     = 1'b0;
    w_sup    = 1'b0;
    w_an_sel = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_nib       = r_disp_data[4*i +: 4];
        w_dp_bit    = r_disp_dp[i];
        w_en        = i_digit_en[i];
        w_sup       = i_lz_en & w_suppress[i];
        w_an_sel[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_an         <= '1;
      o_seg        <= 7'h7F;
      o_dp         <= 1'b1;
      o_frame_done <= 1'b0;
    end else begin
      if (!w_en) begin
        o_an  <= '1;
        o_seg <= 7'h7F;
        o_dp  <= 1'b1;
      end else begin
        o_an  <= w_an_sel;
        o_seg <= w_sup ? 7'h7F : f_decode(w_nib);
        o_dp  <= ~w_dp_bit;
      end
      o_frame_done <= w_wrap;
    end
  end

  assign o_busy = r_pend_valid;

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

  localparam int D = 4;
  localparam int C = 4;
  localparam int FRAME = D * C;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E };

  logic            clk = 1'b0;
  logic            rst;
  logic [4*D-1:0]  data;
  logic [D-1:0]    dp_in;
  logic [D-1:0]    digit_en;
  logic            lz_en;
  logic            load;
  logic [6:0]      seg;
  logic            dp;
  logic [D-1:0]    an;
  logic            frame_done;
  logic            busy;

  always #5 clk = ~clk;

  seg7_scan_driver #(.DIGITS(D), .CLK_DIV(C)) dut (
    .i_clk(clk), .i_rst(rst), .i_data(data), .i_dp_in(dp_in),
    .i_digit_en(digit_en), .i_lz_en(lz_en), .i_load(load),
    .o_seg(seg), .o_dp(dp), .o_an(an), .o_frame_done(frame_done),
    .o_busy(busy));

  // expected word: {seg[6:0], dp, an[3:0], frame_done, busy}
  logic [13:0] exp_q [$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // reference model state
  int          m_k;
  logic [15:0] m_disp, m_pend;
  logic [3:0]  m_ddp, m_pdp;
  logic        m_pv;

  function automatic logic [13:0] model_edge();
    logic [6:0] e_seg;
    logic       e_dp, e_fd;
    logic [3:0] e_an;
    int         idx;
    logic [15:0] upper;
    logic        sup, wrap;
    if (rst) begin
      m_k = 0; m_disp = '0; m_ddp = '0; m_pend = '0; m_pdp = '0; m_pv = 1'b0;
      return {7'h7F, 1'b1, 4'hF, 1'b0, 1'b0};
    end
    idx   = (m_k / C) % D;
    upper = m_disp >> (4 * idx);
    sup   = lz_en && (idx > 0) && (upper == 16'h0);
    if (!digit_en[idx]) begin
      e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF;
    end else begin
      e_an  = ~(4'b0001 << idx);
      e_seg = sup ? 7'h7F : SEG_TAB[upper[3:0]];
      e_dp  = ~m_ddp[idx];
    end
    wrap = (m_k % FRAME) == FRAME - 1;
    e_fd = wrap;
    if (wrap && m_pv) begin
      m_disp = m_pend; m_ddp = m_pdp; m_pv = 1'b0;
    end
    if (load) begin
      m_pend = data; m_pdp = dp_in; m_pv = 1'b1;
    end
    m_k++;
    return {e_seg, e_dp, e_an, e_fd, m_pv};
  endfunction

  // inputs are set at the negedge before calling; load self-clears
  task automatic step();
    @(posedge clk);
    exp_q.push_back(model_edge());
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_until(input int phase);
    int guard = 0;
    while ((m_k % FRAME) != phase && guard < 2 * FRAME) begin
      step();
      guard++;
    end
    if (guard >= 2 * FRAME) begin
      n_cmp++; n_bad++;
      $display("FAIL run_until phase=%0d not reached, k=%0d", phase, m_k);
    end
  endtask

  // monitor: compare each expected word away from the active edge
  always @(negedge clk) begin
    logic [13:0] e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {seg, dp, an, frame_done, busy};
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL out@cyc%0d got seg=%h dp=%b an=%h fd=%b busy=%b exp seg=%h dp=%b an=%h fd=%b busy=%b",
                 cyc, a[13:7], a[6], a[5:2], a[1], a[0], e[13:7], e[6], e[5:2], e[1], e[0]);
      end
    end
    cyc++;
  end

  initial begin
    rst = 1'b1; data = '0; dp_in = '0; digit_en = 4'hF; lz_en = 1'b0; load = 1'b0;
    m_k = 0; m_disp = '0; m_pend = '0; m_ddp = '0; m_pdp = '0; m_pv = 1'b0;
    @(negedge clk);
    run(2);
    rst = 1'b0;
    run(40);                               // scan E,D,B,7 with frame_done every 16

    data = 16'hF5B0; load = 1'b1; run(40); // decode check

    run_until(6);
    data = 16'h1234; load = 1'b1; run(40); // mid-frame load, tear-free

    run_until(3);
    data = 16'h1111; load = 1'b1; step();
    run_until(FRAME - 1);
    data = 16'h2222; load = 1'b1; step(); // load on the wrap edge
    run(40);

    data = 16'h0050; dp_in = 4'b0100; load = 1'b1; lz_en = 1'b1; run(40);
    digit_en = 4'b1110; run(20);

    digit_en = 4'hF; lz_en = 1'b0;
    run_until(7);
    data = 16'hABCD; dp_in = 4'b0101; load = 1'b1; step();
    run_until(9);                          // inside digit 2 slot, pending valid
    rst = 1'b1; step();
    rst = 1'b0; run(20);

    for (int i = 0; i < 600; i++) begin
      rst  = ($urandom_range(0, 99) == 0);
      load = ($urandom_range(0, 7) == 0);
      data = 16'($urandom);
      if ($urandom_range(0, 1) == 0) data[15:8] = 8'h00;
      dp_in = 4'($urandom);
      if ((i % 20) == 0) begin
        digit_en = 4'($urandom);
        lz_en    = 1'($urandom);
      end
      step();
    end
    rst = 1'b0;
    run(3);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain left=%0d exp=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Parametrised, time-multiplexed driver for a DIGITS-wide common-anode seven-segment display.
- Holds a double-buffered frame of hex nibbles plus decimal points and scans one digit at a time at a prescaled rate.
- Decodes each nibble to active-low segments and supports per-digit blanking and leading-zero suppression.
- Sits between application logic (value producers) and the board's seg/an/dp pins.

Parameters:
- DIGITS, 8, number of digits scanned; legal range 1..8.
- CLK_DIV, 100000, clk cycles per digit slot; legal range >= 2.
- IDX_W, $clog2(DIGITS) (minimum 1), width of the digit index (derived, not overridden).

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- data  in  4*DIGITS  nibble i = data[4i+3:4i] is digit i; digit 0 is rightmost/least significant.
- dp_in  in  DIGITS  decimal point request per digit, active-high.
- digit_en  in  DIGITS  per-digit enable, active-high; read live, not buffered.
- lz_en  in  1  leading-zero suppression enable; read live.
- load  in  1  single-cycle strobe that captures data/dp_in into the pending buffer.
- seg  out  7  active-low segments; seg[0]=a … seg[6]=g; registered.
- dp  out  1  active-low decimal point; registered.
- an  out  DIGITS  active-low anode selects, at most one low; registered.
- frame_done  out  1  one-cycle pulse on each frame wrap; registered.
- busy  out  1  high while a pending load awaits commit.

Behaviour:
- Reset values (synchronous, on the clk edge with rst=1): prescaler=0, idx=0, disp_data=0, disp_dp=0, pending_valid=0, an=all 1s, seg=7'h7F, dp=1, frame_done=0, busy=0. rst overrides all other inputs.
- Prescaler counts 0..CLK_DIV-1. tick is asserted when prescaler==CLK_DIV-1; the prescaler then returns to 0.
- On tick, idx advances by one. From DIGITS-1 it wraps to 0; this is the frame wrap.
- Load capture: at a clk edge with load=1, pending_data<=data, pending_dp<=dp_in, pending_valid<=1. A later load before commit overwrites pending; last load wins.
- Commit happens only at a frame-wrap edge with pending_valid=1: disp<=pending, pending_valid<=0. This makes updates tear-free.
- load and frame wrap on the same edge: the commit uses the pending contents held before that edge. The new load is captured into pending and pending_valid stays 1, so it commits at the next wrap. If pending_valid was 0, the new load is captured and waits for the next wrap.
- busy = pending_valid, driven directly from the register.
- frame_done is 1 for exactly the cycle after a frame-wrap edge.
- Output pipeline: an/seg/dp are registered from the current idx and disp. Outputs therefore lag idx by 1 cycle. The first cycle after rst deasserts shows digit 0.
- Digit i disabled (digit_en[i]=0): an all 1s, seg=7F, dp=1 for that slot; timing is unchanged.
- Leading-zero suppression: with lz_en=1, digit i>0 is suppressed when disp nibbles i..DIGITS-1 are all 0. A suppressed digit has its anode active, seg=7F, and dp=~disp_dp[i]. Digit 0 is never suppressed.
- Decode table (seg hex, g..a): 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E.
- DIGITS=1: idx is constant 0 and every tick is a frame wrap.
- Frame period = DIGITS*CLK_DIV cycles.

Test Plan:
- Reset/scan: DIGITS=4, CLK_DIV=4. Release rst → an sequence E,D,B,7, each held 4 cycles. frame_done pulses every 16 cycles.
- Decode: load data=16'hF5B0 and wait one wrap → seg per slot: digit0=40, digit1=03, digit2=12, digit3=0E. dp=1 throughout.
- Tear-free update: load 16'h1234 mid-frame → displayed value changes only after the next frame_done. busy is 1 from the load until the commit.
- Load on wrap edge: pending holds 16'h1111; load 16'h2222 exactly at a wrap → 1111 is displayed this frame and 2222 the next. busy stays 1 across the wrap.
- LZ and blanking: data=16'h0050, lz_en=1 → digits 3 and 2 have seg=7F with their anodes active; digit1=12, digit0=40. Then digit_en=4'b1110 → digit0 slot has an=F, seg=7F.
- Reset mid-frame: assert rst during digit 2 with pending_valid=1 → next cycle an=F, seg=7F, busy=0, disp=0, and scan restarts at digit 0.
